video_timing_sequencer: RTL and testbench
=========================================

Name: video_timing_sequencer

Overview:
Generates raster timing and per-channel control symbols that drive the three byte_to_tmds encoders (blue = ch0, green = ch1, red = ch2) of the HDMI transmitter. It produces video_data_enable, the c0/c1 pairs for every channel, an HDMI video preamble and guard-band flag, and pixel coordinates for the pixel source. It sits between the frame source and the encoders in the pixel_clock domain.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync width in lines
V_BACK, 33, vertical back porch
HSYNC_ACTIVE_HIGH, 0, hsync polarity (1 = high during sync)
VSYNC_ACTIVE_HIGH, 0, vsync polarity
HDMI_MODE, 1, 1 = emit preamble and guard band; 0 = plain DVI
COUNT_WIDTH, 12, width of the h/v counters and coordinate outputs

Ports:
pixel_clock  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high
pixel_request  out  1  high one cycle before each video_data_enable cycle
request_x  out  COUNT_WIDTH  x of the pixel requested (valid while pixel_request)
request_y  out  COUNT_WIDTH  y of the pixel requested
video_data_enable  out  1  active-video cycle; to all encoders
ch0_c0  out  1  hsync level
ch0_c1  out  1  vsync level
ch1_c0  out  1  CTL0
ch1_c1  out  1  CTL1
ch2_c0  out  1  CTL2
ch2_c1  out  1  CTL3
guard_band  out  1  video guard-band cycle; serializer substitutes guard symbols
frame_start  out  1  one-cycle pulse at h=0, v=0

Behaviour:
- One clock (pixel_clock); reset is synchronous and active-high. Everything is evaluated on the rising edge.
- H_TOTAL = sum of the four H parameters (800 at default). V_TOTAL = sum of the four V parameters (525 at default).
- h_count runs 0..H_TOTAL-1 and wraps to 0. v_count increments on each h wrap and wraps at V_TOTAL-1.
- Horizontal regions: active 0..H_ACTIVE-1, then front porch, then sync (default h = 656..751), then back porch.
- Vertical regions are ordered the same way (default sync lines 490..491).
- All outputs are registered and reflect the counter value held after the same edge.
- video_data_enable = (h < H_ACTIVE) and (v < V_ACTIVE).
- pixel_request, request_x and request_y are a one-cycle-early decode of the next counter value, so they lead video_data_enable by exactly 1 cycle, including across line and frame wrap.
- ch0_c0 = hsync at its configured polarity. ch0_c1 = vsync at its configured polarity.
- Outside the preamble, CTL0..CTL3 = 0.
- Preamble applies when HDMI_MODE=1 and the next line (v+1, with wrap) is active:
  - h = H_TOTAL-10 .. H_TOTAL-3: CTL0..CTL3 = 1,0,0,0 for 8 cycles.
  - h = H_TOTAL-2 .. H_TOTAL-1: guard_band = 1 for 2 cycles, CTL bits = 0.
- When HDMI_MODE=0, guard_band and CTL0..CTL3 stay 0.
- guard_band and video_data_enable are never high together.
- Reset:
  - Counters load h = H_TOTAL-1, v = V_TOTAL-1.
  - Outputs go idle: video_data_enable, pixel_request, guard_band, frame_start and CTL bits = 0; coordinates = 0; sync pins at their inactive level.
  - pixel_request is forced 0 while reset is high.
  - On the first edge with reset low, counters reach (0,0). Outputs show video_data_enable=1 and frame_start=1.
  - The first line after reset has no preamble or guard band; this is accepted behaviour.
- Reset asserted mid-line or mid-frame takes effect on the next edge, with no partial-line completion.

Decomposition:
- Shared package video_timing_pkg holds: the default 640x480@60 timing constants, the preamble CTL code (4'b0001, CTL0 = LSB), the preamble length (8) and guard-band length (2).
- One sub-module: timing_counter. It holds the h/v counters with wrap and exposes current and next values. The sequencer decodes regions, sync, preamble and guard band from it.

Test Plan:
- Reset release: reset high for 3 cycles, then low. First edge gives video_data_enable=1, frame_start=1, ch0_c0=1 (inactive, negative polarity). pixel_request was 0 throughout reset.
- Line timing on line 0: video_data_enable high for 640 cycles then low for 160. ch0_c0 low exactly at h=656..751. pixel_request rises exactly 1 cycle before each video_data_enable rise, with request_x=0 and request_y equal to the line.
- Frame timing: ch0_c1 low for 1600 consecutive cycles, on lines 490..491. frame_start period is 420000 cycles.
- Preamble, HDMI_MODE=1: at the end of line 0, ch1_c0=1 for 8 cycles (h=790..797) with the other CTL bits 0. guard_band=1 at h=798..799. video_data_enable rises at the next h=0. End of line 479: no preamble and no guard band. End of line 524: preamble present.
- HDMI_MODE=0: over a full frame, guard_band and all CTL bits stay 0, and sync timing is identical to the HDMI_MODE=1 run.
- Mid-frame reset at v=200, h=300: the next edge shows all outputs idle. After release, counters restart at (0,0) with frame_start=1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster timing constants and HDMI control codes
package video_timing_pkg;
  // 640x480@60 raster
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Video preamble CTL3..CTL0, CTL0 is the LSB
  localparam logic [3:0] PREAMBLE_CTL = 4'b0001;
  localparam int         PREAMBLE_LEN = 8;
  localparam int         GUARD_LEN    = 2;
endpackage

// File: rtl/video_timing_sequencer_if.sv
// rtl/video_timing_sequencer_if.sv - timing/control bundle from sequencer to encoders and pixel source
interface video_timing_sequencer_if #(
  parameter int COUNT_WIDTH = 12
);
  logic                   pixel_request;
  logic [COUNT_WIDTH-1:0] request_x;
  logic [COUNT_WIDTH-1:0] request_y;
  logic                   video_data_enable;
  logic                   ch0_c0;
  logic                   ch0_c1;
  logic                   ch1_c0;
  logic                   ch1_c1;
  logic                   ch2_c0;
  logic                   ch2_c1;
  logic                   guard_band;
  logic                   frame_start;

  modport master (
    output pixel_request, request_x, request_y, video_data_enable,
           ch0_c0, ch0_c1, ch1_c0, ch1_c1, ch2_c0, ch2_c1, guard_band, frame_start
  );

  modport slave (
    input pixel_request, request_x, request_y, video_data_enable,
          ch0_c0, ch0_c1, ch1_c0, ch1_c1, ch2_c0, ch2_c1, guard_band, frame_start
  );
endinterface

// File: rtl/video_timing_sequencer_counter.sv
// rtl/video_timing_sequencer_counter.sv - h/v raster counters exposing the next two positions
module timing_counter #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int COUNT_WIDTH = 12
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  output logic [COUNT_WIDTH-1:0] h_next_o,
  output logic [COUNT_WIDTH-1:0] v_next_o,
  output logic [COUNT_WIDTH-1:0] h_after_o,
  output logic [COUNT_WIDTH-1:0] v_after_o
);
  localparam logic [COUNT_WIDTH-1:0] H_LAST = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST = COUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] h_q, v_q, h_d, v_d, h_a, v_a;

  // Position after the coming edge (d) and the one after that (a), both with line/frame wrap
  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + ONE;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
    h_a = (h_d == H_LAST) ? '0 : h_d + ONE;
    v_a = v_d;
    if (h_d == H_LAST) v_a = (v_d == V_LAST) ? '0 : v_d + ONE;
  end

  // Reset parks on the last pixel of the frame so the first free-running edge lands on (0,0)
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      h_q <= H_LAST;
      v_q <= V_LAST;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_next_o  = h_d;
  assign v_next_o  = v_d;
  assign h_after_o = h_a;
  assign v_after_o = v_a;
endmodule

// File: rtl/video_timing_sequencer.sv
// rtl/video_timing_sequencer.sv - raster timing, sync/CTL symbols, HDMI preamble and guard band
module video_timing_sequencer
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE          = DEF_H_ACTIVE,
  parameter int H_FRONT           = DEF_H_FRONT,
  parameter int H_SYNC            = DEF_H_SYNC,
  parameter int H_BACK            = DEF_H_BACK,
  parameter int V_ACTIVE          = DEF_V_ACTIVE,
  parameter int V_FRONT           = DEF_V_FRONT,
  parameter int V_SYNC            = DEF_V_SYNC,
  parameter int V_BACK            = DEF_V_BACK,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0,
  parameter int HDMI_MODE         = 1,
  parameter int COUNT_WIDTH       = 12
) (
  input logic                      pixel_clock,
  input logic                      reset,
  video_timing_sequencer_if.master vif
);
  localparam int CW      = COUNT_WIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_ACT       = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_ACT       = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] PRE_BEG     = CW'(H_TOTAL - GUARD_LEN - PREAMBLE_LEN);
  localparam logic [CW-1:0] GUARD_BEG   = CW'(H_TOTAL - GUARD_LEN);
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic          HS_POL      = (HSYNC_ACTIVE_HIGH != 0);
  localparam logic          VS_POL      = (VSYNC_ACTIVE_HIGH != 0);
  localparam logic          HDMI_EN     = (HDMI_MODE != 0);

  logic [CW-1:0] h_d, v_d, h_a, v_a, v_following;
  logic          act_d, act_a, hs_d, vs_d, pre_line, pre_d, guard_d;

  logic          de_q, pr_q, hs_q, vs_q, guard_q, fs_q;
  logic [3:0]    ctl_q;
  logic [CW-1:0] rx_q, ry_q;

  timing_counter #(
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .COUNT_WIDTH(CW)
  ) u_counter (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .h_next_o   (h_d),
    .v_next_o   (v_d),
    .h_after_o  (h_a),
    .v_after_o  (v_a)
  );

  // Region decode of the post-edge position, plus one-ahead decode for the pixel request
  always_comb begin
    act_d       = (h_d < H_ACT) && (v_d < V_ACT);
    act_a       = (h_a < H_ACT) && (v_a < V_ACT);
    hs_d        = (h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END);
    vs_d        = (v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END);
    v_following = (v_d == V_LAST) ? '0 : v_d + ONE;
    pre_line    = HDMI_EN && (v_following < V_ACT);
    pre_d       = pre_line && (h_d >= PRE_BEG) && (h_d < GUARD_BEG);
    guard_d     = pre_line && (h_d >= GUARD_BEG);
  end

  // Registered outputs; reset drives everything idle with sync pins at their inactive level
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      de_q    <= 1'b0;
      pr_q    <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ctl_q   <= 4'b0000;
      guard_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      de_q    <= act_d;
      pr_q    <= act_a;
      rx_q    <= act_a ? h_a : '0;
      ry_q    <= act_a ? v_a : '0;
      hs_q    <= hs_d ~^ HS_POL;
      vs_q    <= vs_d ~^ VS_POL;
      ctl_q   <= pre_d ? PREAMBLE_CTL : 4'b0000;
      guard_q <= guard_d;
      fs_q    <= (h_d == '0) && (v_d == '0);
    end
  end

  assign vif.video_data_enable = de_q;
  assign vif.pixel_request     = pr_q;
  assign vif.request_x         = rx_q;
  assign vif.request_y         = ry_q;
  assign vif.ch0_c0            = hs_q;
  assign vif.ch0_c1            = vs_q;
  assign vif.ch1_c0            = ctl_q[0];
  assign vif.ch1_c1            = ctl_q[1];
  assign vif.ch2_c0            = ctl_q[2];
  assign vif.ch2_c1            = ctl_q[3];
  assign vif.guard_band        = guard_q;
  assign vif.frame_start       = fs_q;
endmodule

// File: tb/tb_video_timing_sequencer.sv
// tb/tb_video_timing_sequencer.sv - directed checks of raster, sync, preamble and reset behaviour
module tb_video_timing_sequencer;
  // Reduced raster: H 16+4+6+6=32 (sync h=20..25, preamble 22..29, guard 30..31)
  //                 V 6+2+2+3=13 (sync lines 8..9), frame = 416 cycles
  localparam int CW    = 8;
  localparam int HT    = 32;
  localparam int FRAME = 416;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  video_timing_sequencer_if #(.COUNT_WIDTH(CW)) vif_h ();
  video_timing_sequencer_if #(.COUNT_WIDTH(CW)) vif_d ();

  video_timing_sequencer #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HSYNC_ACTIVE_HIGH(0), .VSYNC_ACTIVE_HIGH(0), .HDMI_MODE(1), .COUNT_WIDTH(CW)
  ) dut_hdmi (
    .pixel_clock(clk), .reset(rst), .vif(vif_h)
  );

  video_timing_sequencer #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HSYNC_ACTIVE_HIGH(0), .VSYNC_ACTIVE_HIGH(0), .HDMI_MODE(0), .COUNT_WIDTH(CW)
  ) dut_dvi (
    .pixel_clock(clk), .reset(rst), .vif(vif_d)
  );

  logic          r_de [0:FRAME];
  logic          r_pr [0:FRAME];
  logic          r_hs [0:FRAME];
  logic          r_vs [0:FRAME];
  logic          r_gb [0:FRAME];
  logic          r_fs [0:FRAME];
  logic [3:0]    r_ctl[0:FRAME];
  logic [CW-1:0] r_rx [0:FRAME];
  logic [CW-1:0] r_ry [0:FRAME];
  logic          d_de [0:FRAME];
  logic          d_hs [0:FRAME];
  logic          d_vs [0:FRAME];
  logic          d_gb [0:FRAME];
  logic [3:0]    d_ctl[0:FRAME];

  function automatic logic [3:0] ctl_h();
    return {vif_h.ch2_c1, vif_h.ch2_c0, vif_h.ch1_c1, vif_h.ch1_c0};
  endfunction

  function automatic logic [3:0] ctl_d();
    return {vif_d.ch2_c1, vif_d.ch2_c0, vif_d.ch1_c1, vif_d.ch1_c0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_de"},  32'(vif_h.video_data_enable), 32'd0);
    chk({tag, "_pr"},  32'(vif_h.pixel_request), 32'd0);
    chk({tag, "_gb"},  32'(vif_h.guard_band), 32'd0);
    chk({tag, "_fs"},  32'(vif_h.frame_start), 32'd0);
    chk({tag, "_ctl"}, 32'(ctl_h()), 32'd0);
    chk({tag, "_hs"},  32'(vif_h.ch0_c0), 32'd1);
    chk({tag, "_vs"},  32'(vif_h.ch0_c1), 32'd1);
    chk({tag, "_rx"},  32'(vif_h.request_x), 32'd0);
    chk({tag, "_ry"},  32'(vif_h.request_y), 32'd0);
  endtask

  initial begin
    int cnt;
    int lead_bad;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("reset");
    end
    rst = 1'b0;

    // Capture one full frame plus the first cycle of the next, k = 0 is the release edge
    step();
    chk("rel_de", 32'(vif_h.video_data_enable), 32'd1);
    chk("rel_fs", 32'(vif_h.frame_start), 32'd1);
    chk("rel_hs", 32'(vif_h.ch0_c0), 32'd1);
    chk("rel_pr", 32'(vif_h.pixel_request), 32'd1);
    chk("rel_rx", 32'(vif_h.request_x), 32'd1);
    for (int k = 0; k <= FRAME; k++) begin
      r_de[k]  = vif_h.video_data_enable;
      r_pr[k]  = vif_h.pixel_request;
      r_hs[k]  = vif_h.ch0_c0;
      r_vs[k]  = vif_h.ch0_c1;
      r_gb[k]  = vif_h.guard_band;
      r_fs[k]  = vif_h.frame_start;
      r_ctl[k] = ctl_h();
      r_rx[k]  = vif_h.request_x;
      r_ry[k]  = vif_h.request_y;
      d_de[k]  = vif_d.video_data_enable;
      d_hs[k]  = vif_d.ch0_c0;
      d_vs[k]  = vif_d.ch0_c1;
      d_gb[k]  = vif_d.guard_band;
      d_ctl[k] = ctl_d();
      if (k != FRAME) step();
    end

    // Line 0: 16 active, hsync low at h=20..25
    cnt = 0;
    for (int k = 0; k < HT; k++) if (r_de[k]) cnt++;
    chk("l0_de_count", 32'(cnt), 32'd16);
    chk("l0_de_h15", 32'(r_de[15]), 32'd1);
    chk("l0_de_h16", 32'(r_de[16]), 32'd0);
    cnt = 0;
    for (int k = 0; k < HT; k++) if (!r_hs[k]) cnt++;
    chk("l0_hs_count", 32'(cnt), 32'd6);
    chk("l0_hs_h19", 32'(r_hs[19]), 32'd1);
    chk("l0_hs_h20", 32'(r_hs[20]), 32'd0);
    chk("l0_hs_h25", 32'(r_hs[25]), 32'd0);
    chk("l0_hs_h26", 32'(r_hs[26]), 32'd1);

    // Pixel request leads enable by one cycle everywhere, coordinates name the next pixel
    lead_bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (r_pr[k] !== r_de[k+1]) lead_bad++;
      if (r_pr[k] && (r_rx[k] !== CW'((k + 1) % HT) || r_ry[k] !== CW'(((k + 1) / HT) % 13)))
        lead_bad++;
    end
    chk("pr_lead_errors", 32'(lead_bad), 32'd0);
    chk("pr_h15", 32'(r_pr[15]), 32'd0);
    chk("pr_l1_rise", 32'(r_pr[31]), 32'd1);
    chk("pr_l1_rx", 32'(r_rx[31]), 32'd0);
    chk("pr_l1_ry", 32'(r_ry[31]), 32'd1);
    chk("pr_wrap", 32'(r_pr[415]), 32'd1);
    chk("pr_wrap_ry", 32'(r_ry[415]), 32'd0);

    // Vsync low on lines 8..9 only, frame_start once per 416 cycles
    cnt = 0;
    for (int k = 0; k < FRAME; k++) if (!r_vs[k]) cnt++;
    chk("vs_count", 32'(cnt), 32'd64);
    chk("vs_k255", 32'(r_vs[255]), 32'd1);
    chk("vs_k256", 32'(r_vs[256]), 32'd0);
    chk("vs_k319", 32'(r_vs[319]), 32'd0);
    chk("vs_k320", 32'(r_vs[320]), 32'd1);
    cnt = 0;
    for (int k = 0; k < FRAME; k++) if (r_fs[k]) cnt++;
    chk("fs_count", 32'(cnt), 32'd1);
    chk("fs_period", 32'(r_fs[FRAME]), 32'd1);

    // Preamble and guard band at end of line 0
    cnt = 0;
    for (int k = 0; k < HT; k++) if (r_ctl[k] == 4'b0001) cnt++;
    chk("pre_l0_count", 32'(cnt), 32'd8);
    chk("pre_l0_h21", 32'(r_ctl[21]), 32'h0);
    chk("pre_l0_h22", 32'(r_ctl[22]), 32'h1);
    chk("pre_l0_h29", 32'(r_ctl[29]), 32'h1);
    chk("pre_l0_h30", 32'(r_ctl[30]), 32'h0);
    chk("gb_l0_h29", 32'(r_gb[29]), 32'd0);
    chk("gb_l0_h30", 32'(r_gb[30]), 32'd1);
    chk("gb_l0_h31", 32'(r_gb[31]), 32'd1);
    chk("de_l1_h0", 32'(r_de[32]), 32'd1);

    // Last active line 5: nothing; last frame line 12: preamble present
    cnt = 0;
    for (int k = 5 * HT; k < 6 * HT; k++) if (r_ctl[k] != 4'b0 || r_gb[k]) cnt++;
    chk("pre_l5_none", 32'(cnt), 32'd0);
    chk("pre_l12_h21", 32'(r_ctl[405]), 32'h0);
    chk("pre_l12_h22", 32'(r_ctl[406]), 32'h1);
    chk("pre_l12_h29", 32'(r_ctl[413]), 32'h1);
    chk("gb_l12_h30", 32'(r_gb[414]), 32'd1);
    chk("gb_l12_h31", 32'(r_gb[415]), 32'd1);

    cnt = 0;
    for (int k = 0; k < FRAME; k++) if (r_gb[k] && r_de[k]) cnt++;
    chk("gb_de_overlap", 32'(cnt), 32'd0);

    // DVI instance: no CTL/guard activity, identical sync and enable timing
    cnt = 0;
    for (int k = 0; k < FRAME; k++) if (d_ctl[k] != 4'b0 || d_gb[k]) cnt++;
    chk("dvi_ctl_gb", 32'(cnt), 32'd0);
    cnt = 0;
    for (int k = 0; k < FRAME; k++)
      if (d_hs[k] !== r_hs[k] || d_vs[k] !== r_vs[k] || d_de[k] !== r_de[k]) cnt++;
    chk("dvi_sync_match", 32'(cnt), 32'd0);

    // Mid-frame reset at line 3, h=10 (k = 416 + 106 = 522)
    repeat (105) step();
    chk("mid_pos_de", 32'(vif_h.video_data_enable), 32'd1);
    chk("mid_pos_fs", 32'(vif_h.frame_start), 32'd0);
    rst = 1'b1;
    step();
    chk_idle("mid_reset");
    rst = 1'b0;
    step();
    chk("mid_rel_de", 32'(vif_h.video_data_enable), 32'd1);
    chk("mid_rel_fs", 32'(vif_h.frame_start), 32'd1);
    chk("mid_rel_vs", 32'(vif_h.ch0_c1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
